// File: rtl/alu_pkg.sv
// Shared definitions for the sign-magnitude ALU sequencing controller:
// operation codes, controller states, operand/result widths and a helper
// that builds a sign-magnitude result without ever producing -0.
package alu_pkg;

  localparam int OPW  = 3;
  localparam int RESW = 5;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // A zero magnitude always gets a positive sign, so -0 never leaves the ALU.
  function automatic logic [RESW-1:0] make_result(input logic neg, input logic [3:0] mag);
    return {neg & (mag != 4'd0), mag};
  endfunction

endpackage

// File: rtl/sm_add_sub_core.sv
// Combinational sign-magnitude adder/subtractor for two 3-bit operands.
// Output is 4-bit sign-magnitude: sign in [3], magnitude in [2:0].
module sm_add_sub_core
  import alu_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  input  logic           sub,
  output logic [3:0]     y
);

  logic       sa;
  logic       sb;
  logic [2:0] ma;
  logic [2:0] mb;
  logic [2:0] mag;
  logic       sign;

  // Subtraction flips B's sign; equal signs add magnitudes, otherwise the larger magnitude wins the sign.
  always_comb begin
    sa   = a[2];
    sb   = b[2] ^ sub;
    ma   = {1'b0, a[1:0]};
    mb   = {1'b0, b[1:0]};
    mag  = 3'd0;
    sign = 1'b0;
    if (sa == sb) begin
      mag  = ma + mb;
      sign = sa;
    end else if (ma >= mb) begin
      mag  = ma - mb;
      sign = sa;
    end else begin
      mag  = mb - ma;
      sign = sb;
    end
    y = {sign & (mag != 3'd0), mag};
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the 3-bit sign-magnitude ALU. ADD/SUB take one
// pass through the add/sub core; MUL is repeated addition and DIV repeated
// subtraction on a local 4-bit accumulator. Results and flags are registered
// and held until the consumer takes them.
module alu_seq_ctrl
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      op,
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [RESW-1:0] result,
  output logic [1:0]      rem,
  output logic            sf,
  output logic            zf,
  output logic            dzf,
  output logic            busy
);

  state_t      state;
  logic [1:0]  lat_op;
  logic        sa;
  logic        sb;
  logic [1:0]  amag;
  logic [1:0]  bmag;
  logic [3:0]  acc;
  logic [1:0]  cnt;

  logic [3:0]      core_y;
  logic [3:0]      sum;
  logic            done_now;
  logic [RESW-1:0] res_n;
  logic [1:0]      rem_n;
  logic            dzf_n;
  logic [3:0]      acc_n;
  logic [1:0]      cnt_n;

  sm_add_sub_core u_core (
    .a   ({sa, amag}),
    .b   ({sb, bmag}),
    .sub (lat_op == OP_SUB),
    .y   (core_y)
  );

  assign sum = acc + {2'b00, amag};

  // One EXEC step: decide whether the operation finishes now and what the next accumulator/counter and result are.
  always_comb begin
    done_now = 1'b0;
    res_n    = '0;
    rem_n    = 2'd0;
    dzf_n    = 1'b0;
    acc_n    = acc;
    cnt_n    = cnt;
    case (lat_op)
      OP_ADD, OP_SUB: begin
        done_now = 1'b1;
        res_n    = make_result(core_y[3], {1'b0, core_y[2:0]});
      end
      OP_MUL: begin
        if (bmag == 2'd0) begin
          done_now = 1'b1;
        end else if (({1'b0, cnt} + 3'd1) == {1'b0, bmag}) begin
          done_now = 1'b1;
          res_n    = make_result(sa ^ sb, sum);
        end else begin
          acc_n = sum;
          cnt_n = cnt + 2'd1;
        end
      end
      OP_DIV: begin
        if (bmag == 2'd0) begin
          done_now = 1'b1;
          dzf_n    = 1'b1;
        end else if (acc >= {2'b00, bmag}) begin
          acc_n = acc - {2'b00, bmag};
          cnt_n = cnt + 2'd1;
        end else begin
          done_now = 1'b1;
          res_n    = make_result(sa ^ sb, {2'b00, cnt});
          rem_n    = acc[1:0];
        end
      end
      default: begin
        done_now = 1'b1;
      end
    endcase
  end

  // Controller FSM with registered handshake, busy, result and flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      rem       <= 2'd0;
      sf        <= 1'b0;
      zf        <= 1'b0;
      dzf       <= 1'b0;
      lat_op    <= OP_ADD;
      sa        <= 1'b0;
      sb        <= 1'b0;
      amag      <= 2'd0;
      bmag      <= 2'd0;
      acc       <= 4'd0;
      cnt       <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            lat_op    <= op;
            sa        <= a[2];
            amag      <= a[1:0];
            sb        <= b[2];
            bmag      <= b[1:0];
            // DIV uses the accumulator as its running remainder, so it starts at |A|.
            acc       <= (op == OP_DIV) ? {2'b00, a[1:0]} : 4'd0;
            cnt       <= 2'd0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          acc <= acc_n;
          cnt <= cnt_n;
          if (done_now) begin
            result    <= res_n;
            rem       <= rem_n;
            sf        <= res_n[4];
            zf        <= (res_n[3:0] == 4'd0);
            dzf       <= dzf_n;
            rsp_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed cases, randomized operations
// against an arithmetic reference model, backpressure and mid-operation reset.
module tb_alu_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] op;
  logic [2:0] a;
  logic [2:0] b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] result;
  logic [1:0] rem;
  logic       sf;
  logic       zf;
  logic       dzf;
  logic       busy;

  int n_cmp;
  int n_err;

  localparam int MAX_WAIT = 20;

  alu_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .result    (result),
    .rem       (rem),
    .sf        (sf),
    .zf        (zf),
    .dzf       (dzf),
    .busy      (busy)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] o;
    logic [2:0] x;
    logic [2:0] y;
    logic [4:0] r;
    logic [1:0] rm;
    logic       d;
    int         e;
  } vec_t;

  // Reference: signed integer arithmetic on decoded operands, re-encoded to sign-magnitude.
  task automatic model(input logic [1:0] o, input logic [2:0] x, input logic [2:0] y,
                       output logic [4:0] r, output logic [1:0] rm, output logic d, output int e);
    int ma, mb, va, vb, v, mag;
    ma = int'(x[1:0]);
    mb = int'(y[1:0]);
    va = x[2] ? -ma : ma;
    vb = y[2] ? -mb : mb;
    rm = 2'd0;
    d  = 1'b0;
    v  = 0;
    e  = 1;
    case (o)
      2'd0: v = va + vb;
      2'd1: v = va - vb;
      2'd2: begin
        v = va * vb;
        e = (mb == 0) ? 1 : mb;
      end
      default: begin
        if (mb == 0) begin
          d = 1'b1;
        end else begin
          mag = ma / mb;
          v   = (x[2] ^ y[2]) ? -mag : mag;
          rm  = 2'(ma % mb);
          e   = mag + 1;
        end
      end
    endcase
    mag = (v < 0) ? -v : v;
    r   = {(v < 0), 4'(mag)};
  endtask

  // Presents one request, scrambles the inputs after acceptance, and counts edges until rsp_valid.
  task automatic issue(input logic [1:0] o, input logic [2:0] x, input logic [2:0] y, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < MAX_WAIT) begin
      @(posedge clk); #1;
      n++;
    end
    op = o; a = x; b = y; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    op = 2'($urandom); a = 3'($urandom); b = 3'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rsp_valid && lat < MAX_WAIT);
  endtask

  // Completes the response handshake.
  task automatic retire();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // Asynchronous reset: outputs cleared while held, req_ready rises after release.
  task automatic test_reset();
    rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; op = 2'd0; a = 3'd0; b = 3'd0;
    #2 rst_n = 1'b0;
    #10;
    n_cmp++;
    if ({req_ready, rsp_valid, busy} !== 3'b000) begin
      n_err++;
      $display("[TB] FAIL reset_handshake: got %b expected 000", {req_ready, rsp_valid, busy});
    end
    n_cmp++;
    if ({result, rem, sf, zf, dzf} !== 10'd0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got %b expected 0", {result, rem, sf, zf, dzf});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", req_ready);
    end
  endtask

  // Directed cases with hand-computed expectations.
  task automatic test_directed();
    vec_t v[7];
    int lat;
    v[0] = '{2'b00, 3'b010, 3'b111, 5'b10001, 2'b00, 1'b0, 1};
    v[1] = '{2'b01, 3'b001, 3'b001, 5'b00000, 2'b00, 1'b0, 1};
    v[2] = '{2'b01, 3'b100, 3'b000, 5'b00000, 2'b00, 1'b0, 1};
    v[3] = '{2'b10, 3'b111, 3'b011, 5'b11001, 2'b00, 1'b0, 3};
    v[4] = '{2'b10, 3'b011, 3'b000, 5'b00000, 2'b00, 1'b0, 1};
    v[5] = '{2'b11, 3'b011, 3'b110, 5'b10001, 2'b01, 1'b0, 2};
    v[6] = '{2'b11, 3'b010, 3'b100, 5'b00000, 2'b00, 1'b1, 1};
    for (int i = 0; i < 7; i++) begin
      issue(v[i].o, v[i].x, v[i].y, lat);
      n_cmp++;
      if (lat !== v[i].e) begin
        n_err++;
        $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, lat, v[i].e);
      end
      n_cmp++;
      if ({result, rem, dzf} !== {v[i].r, v[i].rm, v[i].d}) begin
        n_err++;
        $display("[TB] FAIL dir%0d_result: got r=%b rem=%b dzf=%b expected r=%b rem=%b dzf=%b",
                 i, result, rem, dzf, v[i].r, v[i].rm, v[i].d);
      end
      n_cmp++;
      if ({sf, zf} !== {v[i].r[4], (v[i].r[3:0] == 4'd0)}) begin
        n_err++;
        $display("[TB] FAIL dir%0d_flags: got sf=%b zf=%b expected sf=%b zf=%b",
                 i, sf, zf, v[i].r[4], (v[i].r[3:0] == 4'd0));
      end
      retire();
    end
  endtask

  // Random operations compared against the arithmetic model.
  task automatic test_random();
    logic [1:0] o;
    logic [2:0] x, y;
    logic [4:0] er;
    logic [1:0] erm;
    logic       ed;
    int         ee, lat;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom); x = 3'($urandom); y = 3'($urandom);
      model(o, x, y, er, erm, ed, ee);
      issue(o, x, y, lat);
      n_cmp++;
      if (lat !== ee) begin
        n_err++;
        $display("[TB] FAIL rnd%0d_latency op=%0d a=%b b=%b: got %0d expected %0d", i, o, x, y, lat, ee);
      end
      n_cmp++;
      if ({result, rem, dzf, sf, zf} !== {er, erm, ed, er[4], (er[3:0] == 4'd0)}) begin
        n_err++;
        $display("[TB] FAIL rnd%0d_result op=%0d a=%b b=%b: got r=%b rem=%b dzf=%b sf=%b zf=%b expected r=%b rem=%b dzf=%b",
                 i, o, x, y, result, rem, dzf, sf, zf, er, erm, ed);
      end
      retire();
      n_cmp++;
      if ({req_ready, rsp_valid} !== 2'b10) begin
        n_err++;
        $display("[TB] FAIL rnd%0d_ready_after_rsp: got %b expected 10", i, {req_ready, rsp_valid});
      end
    end
  endtask

  // Held response stays stable under backpressure; a back-to-back request follows the handshake.
  task automatic test_back_to_back();
    logic [9:0] snap;
    int lat;
    issue(2'b10, 3'b010, 3'b110, lat);
    snap = {result, rem, sf, zf, dzf};
    n_cmp++;
    if (snap !== {5'b10100, 2'b00, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL bp_first_result: got %b expected 1010000100", snap);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({rsp_valid, req_ready, busy, result, rem, sf, zf, dzf} !== {3'b101, snap}) begin
        n_err++;
        $display("[TB] FAIL bp_hold%0d: got %b expected %b", i,
                 {rsp_valid, req_ready, busy, result, rem, sf, zf, dzf}, {3'b101, snap});
      end
    end
    retire();
    n_cmp++;
    if ({req_ready, rsp_valid, busy} !== 3'b100) begin
      n_err++;
      $display("[TB] FAIL bp_ready_next: got %b expected 100", {req_ready, rsp_valid, busy});
    end
    issue(2'b01, 3'b011, 3'b101, lat);
    n_cmp++;
    if ({lat == 1, result} !== {1'b1, 5'b00100}) begin
      n_err++;
      $display("[TB] FAIL b2b_sub: got lat=%0d r=%b expected lat=1 r=00100", lat, result);
    end
    retire();
  endtask

  // Reset during the second MUL iteration drops the operation; the next ADD works normally.
  task automatic test_reset_mid();
    int lat;
    op = 2'b10; a = 3'b111; b = 3'b011; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, rsp_valid} !== 2'b10) begin
      n_err++;
      $display("[TB] FAIL mid_in_exec: got %b expected 10", {busy, rsp_valid});
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rsp_valid, busy, req_ready, result, rem, sf, zf, dzf} !== 13'd0) begin
      n_err++;
      $display("[TB] FAIL mid_reset_clear: got %b expected 0",
               {rsp_valid, busy, req_ready, result, rem, sf, zf, dzf});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL mid_no_rsp%0d: got %b expected 0", i, rsp_valid);
      end
    end
    issue(2'b00, 3'b001, 3'b001, lat);
    n_cmp++;
    if ({lat == 1, result, zf} !== {1'b1, 5'b00010, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL mid_add_after: got lat=%0d r=%b zf=%b expected lat=1 r=00010 zf=0", lat, result, zf);
    end
    retire();
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
